// File: rtl/output_port_allocator.sv
// Per-output switch allocator: round-robin arbitration over the input ports,
// wormhole grant hold until the tail flit, and the crossbar mux select.
module output_port_allocator #(
    parameter int                NUM_PORTS = 5,
    parameter int                SEL_W     = 3,
    parameter logic [SEL_W-1:0]  IDLE_SEL  = 3'b111
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [0:NUM_PORTS-1]  req,
    input  logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  out_tail,
    output logic [0:NUM_PORTS-1]  grant,
    output logic [SEL_W-1:0]      sel,
    output logic                  locked
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [SEL_W:0]   NP_EXT   = (SEL_W+1)'(NUM_PORTS);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_PORTS - 1);

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [0:NUM_PORTS-1] grant_q, grant_d;
    logic                 locked_q, locked_d;

    logic                 fire_s;
    logic                 win_found_s;
    logic [SEL_W-1:0]     win_idx_s;
    logic [SEL_W:0]       scan_sum_s;
    logic [SEL_W-1:0]     scan_idx_s;
    logic                 scan_hit_s;

    assign fire_s = out_valid & out_ready & locked_q;

    // Rotating-priority scan: first requester at or after the pointer, modulo port count.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {SEL_W{1'b0}};
        scan_sum_s  = {(SEL_W+1){1'b0}};
        scan_idx_s  = {SEL_W{1'b0}};
        scan_hit_s  = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            scan_sum_s  = {1'b0, ptr_q} + (SEL_W+1)'(k);
            scan_idx_s  = (scan_sum_s >= NP_EXT) ? SEL_W'(scan_sum_s - NP_EXT)
                                                 : SEL_W'(scan_sum_s);
            scan_hit_s  = req[scan_idx_s] & ~win_found_s;
            win_idx_s   = scan_hit_s ? scan_idx_s : win_idx_s;
            win_found_s = win_found_s | scan_hit_s;
        end
    end

    // Next-state and next-output logic for the grant FSM.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        grant_d  = grant_q;
        locked_d = locked_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        grant_d[i] = (win_idx_s == SEL_W'(i));
                    end
                    sel_d    = win_idx_s;
                    locked_d = 1'b1;
                    state_d  = ST_LOCKED;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                // Pointer moves only on release so the next search starts past the winner.
                if (fire_s && out_tail) begin
                    grant_d  = {NUM_PORTS{1'b0}};
                    sel_d    = IDLE_SEL;
                    locked_d = 1'b0;
                    ptr_d    = (sel_q == LAST_IDX) ? {SEL_W{1'b0}} : sel_q + SEL_W'(1);
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_LOCKED;
                end
            end
            default: begin
                grant_d  = {NUM_PORTS{1'b0}};
                sel_d    = IDLE_SEL;
                locked_d = 1'b0;
                ptr_d    = {SEL_W{1'b0}};
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= {SEL_W{1'b0}};
            sel_q    <= IDLE_SEL;
            grant_q  <= {NUM_PORTS{1'b0}};
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            grant_q  <= grant_d;
            locked_q <= locked_d;
        end
    end

    assign grant  = grant_q;
    assign sel    = sel_q;
    assign locked = locked_q;

    output_port_allocator_chk #(
        .NUM_PORTS (NUM_PORTS),
        .SEL_W     (SEL_W),
        .IDLE_SEL  (IDLE_SEL)
    ) u_chk (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .grant  (grant_q),
        .sel    (sel_q),
        .locked (locked_q)
    );

endmodule

// Simulation checks on the request inputs and on the consistency of the outputs.
module output_port_allocator_chk #(
    parameter int                NUM_PORTS = 5,
    parameter int                SEL_W     = 3,
    parameter logic [SEL_W-1:0]  IDLE_SEL  = 3'b111
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [0:NUM_PORTS-1]  req,
    input  logic [0:NUM_PORTS-1]  grant,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  locked
);

    a_req_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(req))
        else $error("req has X/Z bits");

    a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant))
        else $error("grant is not one-hot");

    a_locked_grant: assert property (@(posedge clk) disable iff (rst)
        (locked == (grant != {NUM_PORTS{1'b0}})) && ((sel == IDLE_SEL) == !locked))
        else $error("locked/sel disagree with grant");

    a_sel_matches: assert property (@(posedge clk) disable iff (rst)
        (sel == IDLE_SEL) || ((sel < SEL_W'(NUM_PORTS)) && grant[sel]))
        else $error("sel does not encode grant");

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed bench for output_port_allocator: hand-computed grant/sel/locked
// expectations across arbitration, hold, backpressure and reset scenarios.
module tb_output_port_allocator;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:4] req;
    logic       out_valid;
    logic       out_ready;
    logic       out_tail;
    logic [0:4] grant;
    logic [2:0] sel;
    logic       locked;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    output_port_allocator dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tail  (out_tail),
        .grant     (grant),
        .sel       (sel),
        .locked    (locked)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_out(input string tag, input logic [4:0] g, input logic [2:0] s,
                              input logic l);
        check_eq({tag, ".grant"},  {27'd0, grant},  {27'd0, g});
        check_eq({tag, ".sel"},    {29'd0, sel},    {29'd0, s});
        check_eq({tag, ".locked"}, {31'd0, locked}, {31'd0, l});
    endtask

    // Port p owns the output: grant bit p set (port 0 is the leftmost bit).
    task automatic expect_port(input string tag, input int p);
        expect_out(tag, 5'b10000 >> p, 3'(p), 1'b1);
    endtask

    task automatic expect_idle(input string tag);
        expect_out(tag, 5'b00000, 3'b111, 1'b0);
    endtask

    task automatic set_flit(input logic v, input logic r, input logic t);
        out_valid = v;
        out_ready = r;
        out_tail  = t;
    endtask

    initial begin
        rst = 1'b1;
        req = 5'b00000;
        set_flit(1'b0, 1'b0, 1'b0);
        tick();
        expect_idle("reset");
        rst = 1'b0;
        tick();
        expect_idle("reset.hold");

        // Single requester, three-flit packet, tail on the third.
        req = 5'b00100;
        tick();
        expect_port("single.grant", 2);
        req = 5'b00000;
        set_flit(1'b1, 1'b1, 1'b0);
        tick();
        expect_port("single.flit1", 2);
        tick();
        expect_port("single.flit2", 2);
        set_flit(1'b1, 1'b1, 1'b1);
        tick();
        expect_idle("single.release");

        // Pointer is now 3: between ports 0 and 4, port 4 wins; its release wraps ptr to 0.
        req = 5'b10001;
        tick();
        expect_port("ptr3.pick4", 4);
        req = 5'b00000;
        tick();
        expect_idle("ptr3.release");

        // Round-robin with everybody requesting single-flit packets.
        req = 5'b11111;
        set_flit(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
            expect_port("rr.grant", k % 5);
            tick();
            expect_idle("rr.bubble");
        end

        // Hold under contention: port 1 locked, req moves to port 3 mid-packet.
        req = 5'b01000;
        set_flit(1'b1, 1'b1, 1'b0);
        tick();
        expect_port("hold.grant1", 1);
        req = 5'b00010;
        tick();
        expect_port("hold.body", 1);
        set_flit(1'b0, 1'b1, 1'b1);
        tick();
        expect_port("hold.tail_nofire", 1);
        set_flit(1'b1, 1'b1, 1'b1);
        tick();
        expect_idle("hold.release");
        tick();
        expect_port("hold.grant3", 3);
        req = 5'b00000;
        tick();
        expect_idle("hold.release3");

        // Backpressure on port 4 with tail presented but never accepted.
        req = 5'b00001;
        set_flit(1'b1, 1'b1, 1'b0);
        tick();
        expect_port("bp.grant4", 4);
        req = 5'b00000;
        set_flit(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            tick();
            expect_port("bp.stall", 4);
        end
        set_flit(1'b1, 1'b1, 1'b1);
        tick();
        expect_idle("bp.release");

        // Wrapped pointer is 0: port 0 beats port 4.
        req = 5'b10001;
        tick();
        expect_port("wrap.pick0", 0);
        req = 5'b00000;
        tick();
        expect_idle("wrap.release");

        // Move ptr to 3 via a port-2 packet, then lock port 2 again and reset mid-packet.
        req = 5'b00100;
        tick();
        expect_port("pre_rst.grant2a", 2);
        req = 5'b00000;
        tick();
        expect_idle("pre_rst.release");
        req = 5'b00100;
        set_flit(1'b1, 1'b1, 1'b0);
        tick();
        expect_port("pre_rst.grant2b", 2);
        req = 5'b00000;
        tick();
        expect_port("pre_rst.body", 2);
        #2;
        rst = 1'b1;
        #1;
        expect_idle("rst.async");
        #1;
        rst = 1'b0;
        // Ports 2 and 4 request: a reset pointer (0) picks 2, a stale pointer (3) would pick 4.
        req = 5'b00101;
        set_flit(1'b1, 1'b1, 1'b1);
        tick();
        expect_port("rst.ptr0_pick2", 2);
        req = 5'b00000;
        tick();
        expect_idle("rst.release");

        // Idle stability while flit controls toggle.
        for (int k = 0; k < 20; k++) begin
            set_flit(k[0], 1'b1, k[1]);
            tick();
            expect_idle("idle.stable");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
